// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Address width for non-default NREGS is derived inside each module.
package rf_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with an incrementally maintained popcount.
// A same-cycle reserve and write to one register leaves it pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] pending,
    output logic [CW-1:0]    pending_cnt
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsv_v, wr_v, inc, dec;

    assign rsv_v = rsv_en && (rsv_addr != AW'(REG_ZERO));
    assign wr_v  = wr_en && (wr_addr != AW'(REG_ZERO));

    always_comb begin
        pending_d = pending_q;
        if (wr_v)
            pending_d[wr_addr] = 1'b0;
        if (rsv_v)
            pending_d[rsv_addr] = 1'b1;
    end

    // A write that collides with a reserve never drops the count.
    assign inc = rsv_v && !pending_q[rsv_addr];
    assign dec = wr_v && pending_q[wr_addr]
                 && !(rsv_v && (rsv_addr == wr_addr));

    always_comb begin
        cnt_d = cnt_q;
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending     = pending_q;
    assign pending_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with x0 hardwired to zero, optional
// write-to-read forwarding and a pending-producer scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRP    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS),
    localparam int CW     = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    pending,
    output logic [CW-1:0]       pending_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_v;

    assign wr_v = wr_en && (wr_addr != AW'(REG_ZERO));

    always_comb begin
        for (int r = 0; r < NREGS; r++)
            regs_d[r] = regs_q[r];
        if (wr_v)
            regs_d[wr_addr] = wr_data;
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= regs_d[r];
        end
    end

    rf_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .pending    (pending),
        .pending_cnt(pending_cnt)
    );

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          nz;
        logic          hit;

        assign a   = rd_addr[i*AW +: AW];
        assign nz  = (a != AW'(REG_ZERO));
        // Forwarded data also means the producer has just completed.
        assign hit = (BYPASS != 0) && wr_en && (wr_addr == a) && nz;

        assign rd_data[i*XLEN +: XLEN] = !nz ? '0
                                       : hit ? wr_data
                                       : regs_q[a];
        assign rd_busy[i] = nz && !hit && pending[a];
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 64, register width in bits.
REQ-002 Parameter NREGS, default 32, architectural register count; SHALL be a power of two and at least 2.
REQ-003 Parameter NRP, default 2, number of read ports.
REQ-004 Parameter BYPASS, default 1, 1 = write-to-read forwarding within the cycle; 0 = none.
REQ-005 Derived AW = $clog2(NREGS) and CW = $clog2(NREGS+1); not user-overridable.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 rd_addr  in  NRP*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-009 rd_data  out  NRP*XLEN  packed read data; port i at bits [i*XLEN +: XLEN].
REQ-010 rd_busy  out  NRP  port i source register has an outstanding reservation.
REQ-011 wr_en  in  1  write strobe.
REQ-012 wr_addr  in  AW  write destination.
REQ-013 wr_data  in  XLEN  write value.
REQ-014 rsv_en  in  1  reserve strobe; marks a destination as pending (issue of a producer).
REQ-015 rsv_addr  in  AW  register to reserve.
REQ-016 pending  out  NREGS  per-register pending bits, registered.
REQ-017 pending_cnt  out  CW  population count of pending, registered.

Function
REQ-018 Register 0 SHALL always read 0; writes and reservations addressed to 0 SHALL be ignored.
REQ-019 Reads SHALL be combinational: rd_data[i] = regs[rd_addr[i]], zero latency.
REQ-020 With BYPASS=1 and wr_en=1, wr_addr=rd_addr[i]!=0, rd_data[i] SHALL equal wr_data in the same cycle.
REQ-021 Writes SHALL update regs[wr_addr] at the next rising edge; write-to-read latency is 1 cycle with BYPASS=0, 0 with BYPASS=1.
REQ-022 rsv_en=1, rsv_addr!=0 SHALL set pending[rsv_addr] at the next edge.
REQ-023 wr_en=1, wr_addr!=0 SHALL clear pending[wr_addr] at the next edge.
REQ-024 Reserve and write to the same register in the same cycle: data SHALL be written and pending SHALL end set (new producer wins).
REQ-025 Reserving an already-pending register SHALL leave it pending; pending_cnt unchanged.
REQ-026 Writing a non-pending register SHALL be legal; pending stays clear.
REQ-027 rd_busy[i] = pending[rd_addr[i]], except 0 when rd_addr[i]=0 or (BYPASS=1 and the same-cycle write targets rd_addr[i]).
REQ-028 pending_cnt SHALL be updated incrementally at each edge by +1, -1 or 0 and SHALL always equal the popcount of pending; reaching NREGS-1 is the maximum, no wrap.
REQ-029 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-030 With reset=1 at a rising edge: all regs, pending and pending_cnt SHALL be 0 after that edge.
REQ-031 Reset SHALL take priority over simultaneous wr_en/rsv_en; those operations are discarded.
REQ-032 No initial blocks SHALL be relied on for state values; reset is the only initialisation.

Structure
REQ-033 Package rf_pkg SHALL hold XLEN default, NREGS default, REG_ZERO constant and the reg-address typedef.
REQ-034 Pending bits and pending_cnt SHALL be a sub-module rf_scoreboard (ports clk, reset, rsv_en/addr, wr_en/addr, pending, pending_cnt).
REQ-035 Storage SHALL use one always_ff; next-state in a single always_comb with a default assignment per register (no latches).

Verification
REQ-036 Reset, write x5=0x1234 -> next cycle rd_addr[0]=5 returns 0x1234; rd_addr[1]=0 returns 0.
REQ-037 BYPASS=1: wr_en x7=0xDEAD and rd_addr[0]=7 same cycle -> rd_data[0]=0xDEAD, rd_busy[0]=0; BYPASS=0 -> old value 0.
REQ-038 Reserve x3, x4 -> pending_cnt=2, rd_busy set for x3; write x3 -> pending_cnt=1; reserve+write x4 same cycle -> pending[4]=1, pending_cnt=1.
REQ-039 Write x0=0xFFFF and reserve x0 -> rd_data=0, pending[0]=0, pending_cnt unchanged.
REQ-040 Reserve all 31 registers -> pending_cnt=31; assert reset with wr_en=1 -> all regs 0, pending_cnt=0.
REQ-041 Random write/reserve/read stream checked against reference model of regs and pending for NRP=3, XLEN=32, NREGS=16.
